// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock).
// Produces hundreds/tens/units digits with an optional two-digit clamp to 99.
module bin_to_bcd_seq #(
  parameter int WIDTH = 8,
  parameter bit SAT2  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       cent,
  output logic [3:0]       dez,
  output logic [3:0]       uni,
  output logic             ovf,
  output logic             out_valid,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for in_valid, in_ready high
  // SHIFT | one correct-and-shift step per edge, count down to 0
  // DONE  | BCD nibbles final; next edge publishes the result
  localparam int RW = WIDTH + 12;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] sr, sr_fix;
  logic [CW-1:0] count;
  logic [3:0]    bcd_h, bcd_t, bcd_u;

  assign bcd_h = sr[WIDTH+8 +: 4];
  assign bcd_t = sr[WIDTH+4 +: 4];
  assign bcd_u = sr[WIDTH   +: 4];

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (count == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // All three nibbles are corrected from their pre-correction values.
  always_comb begin
    sr_fix = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        sr_fix[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr    <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= {12'b0, in_data};
            count <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          sr    <= {sr_fix[RW-2:0], 1'b0};
          count <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cent      <= 4'd0;
      dez       <= 4'd0;
      uni       <= 4'd0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == DONE) begin
        out_valid <= 1'b1;
        // Any nonzero hundreds digit means the value exceeds 99.
        if (SAT2 && (bcd_h != 4'd0)) begin
          cent <= 4'd0;
          dez  <= 4'd9;
          uni  <= 4'd9;
          ovf  <= 1'b1;
        end else begin
          cent <= bcd_h;
          dez  <= bcd_t;
          uni  <= bcd_u;
          ovf  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: one full-range and one saturating instance driven in parallel.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;

  logic       in_ready_a, ovf_a, out_valid_a, busy_a;
  logic [3:0] cent_a, dez_a, uni_a;
  logic       in_ready_b, ovf_b, out_valid_b, busy_b;
  logic [3:0] cent_b, dez_b, uni_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  bin_to_bcd_seq #(.WIDTH(8), .SAT2(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .cent(cent_a), .dez(dez_a), .uni(uni_a),
    .ovf(ovf_a), .out_valid(out_valid_a), .busy(busy_a)
  );

  bin_to_bcd_seq #(.WIDTH(8), .SAT2(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .cent(cent_b), .dez(dez_b), .uni(uni_b),
    .ovf(ovf_b), .out_valid(out_valid_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int c, d, u;
    int sc, sd, su, so;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid_a) begin
      pulses++;
      chk("nibble_range", {31'b0, (cent_a <= 4'd9) && (dez_a <= 4'd9) && (uni_a <= 4'd9)}, 1);
      chk("strobe_align", {31'b0, out_valid_b}, 1);
    end
  end

  task automatic chk_digits(input string nm, input int c, input int d, input int u,
                            input int sc, input int sd, input int su, input int so);
    chk({nm, "_cent"}, {28'b0, cent_a}, c);
    chk({nm, "_dez"},  {28'b0, dez_a},  d);
    chk({nm, "_uni"},  {28'b0, uni_a},  u);
    chk({nm, "_ovf"},  {31'b0, ovf_a},  0);
    chk({nm, "_sat_cent"}, {28'b0, cent_b}, sc);
    chk({nm, "_sat_dez"},  {28'b0, dez_b},  sd);
    chk({nm, "_sat_uni"},  {28'b0, uni_b},  su);
    chk({nm, "_sat_ovf"},  {31'b0, ovf_b},  so);
  endtask

  // Called at the negedge after acceptance; returns negedges until the strobe.
  task automatic wait_strobe(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!out_valid_a && lat < 30) begin
      if (busy_a) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) chk("strobe_timeout", 0, 1);
  endtask

  task automatic convert(input int v, output int lat, output int bcnt);
    @(negedge clk);
    in_data  = v[7:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_strobe(lat, bcnt);
  endtask

  vec_t vecs[12];
  int lat, bcnt, lat2, p0;

  initial begin
    vecs[0]  = '{45,  0, 4, 5, 0, 4, 5, 0};
    vecs[1]  = '{255, 2, 5, 5, 0, 9, 9, 1};
    vecs[2]  = '{0,   0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{99,  0, 9, 9, 0, 9, 9, 0};
    vecs[4]  = '{100, 1, 0, 0, 0, 9, 9, 1};
    vecs[5]  = '{37,  0, 3, 7, 0, 3, 7, 0};
    vecs[6]  = '{9,   0, 0, 9, 0, 0, 9, 0};
    vecs[7]  = '{10,  0, 1, 0, 0, 1, 0, 0};
    vecs[8]  = '{199, 1, 9, 9, 0, 9, 9, 1};
    vecs[9]  = '{128, 1, 2, 8, 0, 9, 9, 1};
    vecs[10] = '{250, 2, 5, 0, 0, 9, 9, 1};
    vecs[11] = '{64,  0, 6, 4, 0, 6, 4, 0};

    rst      = 1'b0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cent",      {28'b0, cent_a}, 0);
    chk("rst_dez",       {28'b0, dez_a}, 0);
    chk("rst_uni",       {28'b0, uni_a}, 0);
    chk("rst_ovf",       {31'b0, ovf_b}, 0);
    chk("rst_out_valid", {31'b0, out_valid_a}, 0);
    chk("rst_busy",      {31'b0, busy_a}, 0);
    chk("rst_in_ready",  {31'b0, in_ready_a}, 1);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].v, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, 9);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
      chk($sformatf("vec%0d_in_ready_at_strobe", i), {31'b0, in_ready_a}, 1);
      chk_digits($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].u,
                 vecs[i].sc, vecs[i].sd, vecs[i].su, vecs[i].so);
      @(negedge clk);
      chk($sformatf("vec%0d_strobe_one_cycle", i), {31'b0, out_valid_a}, 0);
    end

    // Busy rejection: extra in_valid pulses during the conversion of 12.
    p0 = pulses;
    @(negedge clk);
    in_data  = 8'd12;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd200;
    chk("rej_in_ready_e2", {31'b0, in_ready_a}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    chk("rej_in_ready_e5", {31'b0, in_ready_a}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_strobe(lat, bcnt);
    chk("rej_latency", lat, 4);
    chk_digits("rej", 0, 1, 2, 0, 1, 2, 0);
    repeat (15) @(negedge clk);
    chk("rej_single_pulse", pulses - p0, 1);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    in_data  = 8'd58;
    in_valid = 1'b1;
    @(negedge clk);
    wait_strobe(lat, bcnt);
    chk("b2b_first_latency", lat, 9);
    chk_digits("b2b_first", 0, 5, 8, 0, 5, 8, 0);
    chk("b2b_in_ready_at_strobe", {31'b0, in_ready_a}, 1);
    in_data = 8'd73;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_accepted", {31'b0, busy_a}, 1);
    wait_strobe(lat2, bcnt);
    chk("b2b_spacing", lat2 + 1, 10);
    chk_digits("b2b_second", 0, 7, 3, 0, 7, 3, 0);

    // Asynchronous reset between edges 4 and 5 of a conversion of 180.
    @(negedge clk);
    in_data  = 8'd180;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_cent", {28'b0, cent_a}, 0);
    chk("mid_rst_dez",  {28'b0, dez_a}, 0);
    chk("mid_rst_uni",  {28'b0, uni_a}, 0);
    chk("mid_rst_busy", {31'b0, busy_a}, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready_a}, 1);
    p0 = pulses;
    repeat (15) @(negedge clk);
    chk("mid_rst_no_strobe", pulses - p0, 0);
    rst = 1'b1;
    convert(7, lat, bcnt);
    chk("post_rst_latency", lat, 9);
    chk_digits("post_rst", 0, 0, 7, 0, 0, 7, 0);

    // Exhaustive sweep against an arithmetic digit model.
    for (int v = 0; v < 256; v++) begin
      convert(v, lat, bcnt);
      chk($sformatf("sweep%0d_latency", v), lat, 9);
      if (v > 99)
        chk_digits($sformatf("sweep%0d", v), v / 100, (v / 10) % 10, v % 10, 0, 9, 9, 1);
      else
        chk_digits($sformatf("sweep%0d", v), 0, v / 10, v % 10, 0, v / 10, v % 10, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (shift-add-3), one shift per clock.
- Sits directly upstream of the LCD character driver; its hundreds/tens/units digits feed the driver's digit inputs.
- Uses a valid/ready handshake on input and a one-cycle result strobe on output.
- Optional two-digit saturation to 99 for the two-character display field.

Parameters:
- WIDTH, 8, binary input width; legal range 4..9, so the result always fits 3 BCD digits (max 511).
- SAT2, 0, 1 = clamp results above 99 to tens=9, units=9, hundreds=0 and raise ovf; 0 = full 3-digit result.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset; 0 = reset asserted
- in_data  input  WIDTH  unsigned binary value to convert
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a value; high only in IDLE
- cent  output  4  hundreds digit, 0..9
- dez  output  4  tens digit, 0..9
- uni  output  4  units digit, 0..9
- ovf  output  1  value exceeded 99 and was clamped; only when SAT2=1, otherwise tied 0
- out_valid  output  1  one-cycle strobe: cent/dez/uni/ovf updated this cycle
- busy  output  1  conversion in progress; high in SHIFT and DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cent=dez=uni=0, ovf=0, out_valid=0, busy=0, in_ready=1.
  - Shift register and counter cleared.
  - Reset asserted mid-conversion aborts the conversion; no out_valid is produced.
- State machine: IDLE, SHIFT, DONE.
  - IDLE:
    - in_ready=1.
    - On an edge with in_valid=1: load {12'b0, in_data} into the working register, count=WIDTH, go to SHIFT. Call this edge E0.
    - in_valid=0: stay in IDLE.
  - SHIFT: each edge does two steps:
    - First, add 3 to every 4-bit BCD nibble that is >=5. All three nibbles are corrected in parallel from pre-correction values.
    - Then shift the whole register left by 1 and decrement count.
    - The edge on which count goes 1->0 (edge E_WIDTH) performs the final shift and moves to DONE.
  - DONE:
    - On the next edge, copy the BCD nibbles into cent/dez/uni, apply saturation, set out_valid=1 for exactly one cycle, and go to IDLE.
- Latency and throughput:
  - Result registers and out_valid are updated on edge E_(WIDTH+1); 9 edges after acceptance for WIDTH=8.
  - in_ready returns high in the same cycle out_valid is high.
  - A new value can be accepted on the following edge, so back-to-back throughput is one conversion per WIDTH+2 edges.
- in_valid while busy: ignored; no queueing. in_data is sampled only at E0, so changes to in_data after acceptance do not affect the running conversion.
- Saturation (SAT2=1): if the converted value is >99, outputs are cent=0, dez=9, uni=9, ovf=1. Otherwise cent=0 and ovf=0. With WIDTH<=6 the clamp can never trigger.
- Output hold: cent/dez/uni/ovf hold their last result until the next DONE edge; out_valid=0 in all other cycles.
- Arithmetic: all unsigned. Working register width is WIDTH+12 bits. Every nibble that reaches the outputs must be 0..9 (asserted in the bench).

Test Plan:
1. Reset then convert: rst low 3 cycles, release, in_data=45, in_valid=1 for 1 cycle -> exactly 9 edges later out_valid=1 for one cycle with cent=0, dez=4, uni=5, ovf=0; busy high for the 9 intervening cycles.
2. Full range, SAT2=0: in_data=255 -> cent=2, dez=5, uni=5. Then in_data=0 -> cent=0, dez=0, uni=0. Then in_data=99 -> 0,9,9.
3. Saturation, SAT2=1: in_data=100 -> cent=0, dez=9, uni=9, ovf=1. Next in_data=37 -> 0,3,7 and ovf=0.
4. Busy rejection: accept 12; at edges 2 and 5 drive in_valid=1 with in_data=200 -> in_ready=0 at those edges, the result is 0,1,2, and only one out_valid pulse occurs.
5. Back-to-back: hold in_valid=1 with in_data=58 then 73 -> second acceptance on the edge after the first out_valid, results 0,5,8 then 0,7,3, strobes spaced 10 edges apart.
6. Reset mid-operation: accept 180, assert rst asynchronously between edges 4 and 5 -> outputs clear to 0 immediately, no out_valid; after release, 7 converts normally to 0,0,7.
7. Exhaustive check: all 256 inputs, SAT2=0, compared against a reference model digit by digit.
